// File: rtl/pixel_pack_fifo_pkg.sv
// Shared types and constants for the pixel packer and its word FIFO.
package pixel_pack_fifo_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned WORD_W = 32;

  typedef logic [1:0] byte_idx_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
  } fifo_entry_t;

  function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Generic show-ahead synchronous FIFO: the head entry is always visible on rdata_o.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo_sa #(
  parameter  int unsigned WIDTH = 33,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is forced to zero while empty so a flushed FIFO reads back like a reset one.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixel_pack_fifo.sv
// Packs 8-bit pixels into 32-bit little-endian words, buffers them and tags frame ends.
// Optional per-frame checksum on frame_sum when PACK_CHECKSUM_EN is defined.
module pixel_pack_fifo
  import pixel_pack_fifo_pkg::*;
#(
  parameter  int unsigned IMG_WIDTH    = 32,
  parameter  int unsigned IMG_HEIGHT   = 32,
  parameter  int unsigned FIFO_DEPTH   = 8,
  localparam int unsigned FRAME_PIXELS = frame_pixels(IMG_WIDTH, IMG_HEIGHT),
  localparam int unsigned LevelW       = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned CntW         = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_empty,
  input  logic              rd_en,
  output logic [LevelW-1:0] level,
  output logic              frame_done,
  output logic              underflow,
  output logic [15:0]       frame_sum
);

  byte_idx_t         byte_idx_q;
  logic [CntW-1:0]   pix_cnt_q;
  logic [WORD_W-1:0] word_q, word_ins;
  logic              frame_done_q, underflow_q;
  logic              last_pix, complete, accept, push, fifo_full;
  fifo_entry_t       push_entry, head_entry;

  assign last_pix  = (pix_cnt_q == CntW'(FRAME_PIXELS - 1));
  assign complete  = (byte_idx_q == 2'd3) || last_pix;
  // Only registered state and clear feed ready_out, keeping rd_en/valid_in off this path.
  assign ready_out = !clear && !(fifo_full && complete);
  assign accept    = valid_in && ready_out;
  assign push      = accept && complete;

  always_comb begin
    word_ins = word_q;
    word_ins[{byte_idx_q, 3'b000} +: PIX_W] = pixel_in;
  end

  assign push_entry.data = word_ins;
  assign push_entry.last = last_pix;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_idx_q   <= '0;
      pix_cnt_q    <= '0;
      word_q       <= '0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else if (clear) begin
      byte_idx_q   <= '0;
      pix_cnt_q    <= '0;
      word_q       <= '0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      frame_done_q <= push && last_pix;
      if (rd_en && rd_empty) underflow_q <= 1'b1;
      if (accept) begin
        byte_idx_q <= complete ? '0 : byte_idx_q + 1'b1;
        pix_cnt_q  <= last_pix ? '0 : pix_cnt_q + 1'b1;
        // Zeroing on push leaves unused upper bytes of a short frame-end word at zero.
        word_q     <= complete ? '0 : word_ins;
      end
    end
  end

  sync_fifo_sa #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (clear),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (rd_en),
    .rdata_o (head_entry),
    .empty_o (rd_empty),
    .full_o  (fifo_full),
    .count_o (level)
  );

  assign rd_data    = head_entry.data;
  assign rd_last    = head_entry.last;
  assign frame_done = frame_done_q;
  assign underflow  = underflow_q;

`ifdef PACK_CHECKSUM_EN
  logic [15:0] sum_acc_q, sum_next, frame_sum_q;

  assign sum_next = sum_acc_q + 16'(pixel_in);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_acc_q   <= '0;
      frame_sum_q <= '0;
    end else if (clear) begin
      sum_acc_q <= '0;
    end else if (accept) begin
      if (last_pix) begin
        frame_sum_q <= sum_next;
        sum_acc_q   <= '0;
      end else begin
        sum_acc_q <= sum_next;
      end
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_pixel_pack_fifo.sv
// Directed bench for pixel_pack_fifo: a 32x32 instance (a_*) and a 3x3 instance (b_*).
module tb_pixel_pack_fifo;

`ifdef PACK_CHECKSUM_EN
  localparam logic [15:0] ExpSum = 16'd45;
`else
  localparam logic [15:0] ExpSum = 16'd0;
`endif

  logic        clk, rstn;
  logic        a_clear, a_valid, a_ready, a_rd_last, a_rd_empty, a_rd_en;
  logic        a_frame_done, a_underflow;
  logic [7:0]  a_pixel;
  logic [31:0] a_rd_data;
  logic [3:0]  a_level;
  logic [15:0] a_frame_sum;
  logic        b_clear, b_valid, b_ready, b_rd_last, b_rd_empty, b_rd_en;
  logic        b_frame_done, b_underflow;
  logic [7:0]  b_pixel;
  logic [31:0] b_rd_data;
  logic [3:0]  b_level;
  logic [15:0] b_frame_sum;

  int n_checks, n_fail, b_done_cnt;

  pixel_pack_fifo #(.IMG_WIDTH(32), .IMG_HEIGHT(32), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rstn(rstn), .clear(a_clear), .pixel_in(a_pixel), .valid_in(a_valid),
    .ready_out(a_ready), .rd_data(a_rd_data), .rd_last(a_rd_last), .rd_empty(a_rd_empty),
    .rd_en(a_rd_en), .level(a_level), .frame_done(a_frame_done), .underflow(a_underflow),
    .frame_sum(a_frame_sum)
  );

  pixel_pack_fifo #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rstn(rstn), .clear(b_clear), .pixel_in(b_pixel), .valid_in(b_valid),
    .ready_out(b_ready), .rd_data(b_rd_data), .rd_last(b_rd_last), .rd_empty(b_rd_empty),
    .rd_en(b_rd_en), .level(b_level), .frame_done(b_frame_done), .underflow(b_underflow),
    .frame_sum(b_frame_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves valid high so consecutive calls are back-to-back.
  task automatic send_a(input logic [7:0] p);
    int waited = 0;
    a_pixel = p;
    a_valid = 1'b1;
    #1;
    while (!a_ready && waited < 20) begin step(); waited++; end
    if (!a_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_a_timeout: ready_out=%0b required 1", a_ready);
    end
    step();
  endtask

  task automatic send_b(input logic [7:0] p);
    int waited = 0;
    b_pixel = p;
    b_valid = 1'b1;
    #1;
    while (!b_ready && waited < 20) begin step(); waited++; end
    if (!b_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_b_timeout: ready_out=%0b required 1", b_ready);
    end
    step();
    if (b_frame_done) b_done_cnt++;
  endtask

  task automatic pop_b();
    b_rd_en = 1'b1;
    step();
    b_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (a_rd_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %0b want 1", a_rd_empty); end
    n_checks++; if (a_level !== 4'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", a_level); end
    n_checks++; if (a_rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", a_rd_data); end
    n_checks++; if (a_rd_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %0b want 0", a_rd_last); end
    n_checks++; if ({a_frame_done, a_underflow} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b want 00", {a_frame_done, a_underflow}); end
    n_checks++; if (a_frame_sum !== 16'd0) begin n_fail++; $display("FAIL rst_sum: got %0d want 0", a_frame_sum); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", a_ready); end
  endtask

  task automatic test_pack();
    send_a(8'h11); send_a(8'h22); send_a(8'h33); send_a(8'h44);
    a_valid = 1'b0;
    n_checks++; if (a_rd_empty !== 1'b0) begin n_fail++; $display("FAIL pack_empty: got %0b want 0", a_rd_empty); end
    n_checks++; if (a_rd_data !== 32'h44332211) begin n_fail++; $display("FAIL pack_data: got %h want 44332211", a_rd_data); end
    n_checks++; if (a_rd_last !== 1'b0) begin n_fail++; $display("FAIL pack_last: got %0b want 0", a_rd_last); end
    n_checks++; if (a_level !== 4'd1) begin n_fail++; $display("FAIL pack_level: got %0d want 1", a_level); end
  endtask

  task automatic test_full();
    a_clear = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %0b want 0", a_ready); end
    step();
    a_clear = 1'b0;
    for (int i = 0; i < 32; i++) send_a(8'(i));
    n_checks++; if (a_level !== 4'd8) begin n_fail++; $display("FAIL full_level: got %0d want 8", a_level); end
    send_a(8'h20); send_a(8'h21); send_a(8'h22);
    a_pixel = 8'h23;
    #1;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", a_ready); end
    a_rd_en = 1'b1;
    step();
    a_rd_en = 1'b0;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL pop_ready: got %0b want 1", a_ready); end
    n_checks++; if (a_level !== 4'd7) begin n_fail++; $display("FAIL pop_level: got %0d want 7", a_level); end
    n_checks++; if (a_rd_data !== 32'h07060504) begin n_fail++; $display("FAIL pop_head: got %h want 07060504", a_rd_data); end
    step();
    a_valid = 1'b0;
    n_checks++; if (a_level !== 4'd8) begin n_fail++; $display("FAIL refill_level: got %0d want 8", a_level); end
  endtask

  task automatic test_frame();
    b_done_cnt = 0;
    for (int i = 1; i <= 9; i++) send_b(8'(i));
    b_valid = 1'b0;
    n_checks++; if (b_frame_done !== 1'b1) begin n_fail++; $display("FAIL frm_done: got %0b want 1", b_frame_done); end
    step(); if (b_frame_done) b_done_cnt++;
    step(); if (b_frame_done) b_done_cnt++;
    n_checks++; if (b_done_cnt !== 1) begin n_fail++; $display("FAIL frm_pulses: got %0d want 1", b_done_cnt); end
    n_checks++; if (b_frame_sum !== ExpSum) begin n_fail++; $display("FAIL frm_sum: got %0d want %0d", b_frame_sum, ExpSum); end
    n_checks++; if (b_level !== 4'd3) begin n_fail++; $display("FAIL frm_level: got %0d want 3", b_level); end
    n_checks++; if ({b_rd_data, b_rd_last} !== {32'h04030201, 1'b0}) begin n_fail++; $display("FAIL frm_w0: got %h/%0b want 04030201/0", b_rd_data, b_rd_last); end
    pop_b();
    n_checks++; if ({b_rd_data, b_rd_last} !== {32'h08070605, 1'b0}) begin n_fail++; $display("FAIL frm_w1: got %h/%0b want 08070605/0", b_rd_data, b_rd_last); end
    pop_b();
    n_checks++; if ({b_rd_data, b_rd_last} !== {32'h00000009, 1'b1}) begin n_fail++; $display("FAIL frm_w2: got %h/%0b want 00000009/1", b_rd_data, b_rd_last); end
    pop_b();
    n_checks++; if (b_rd_empty !== 1'b1) begin n_fail++; $display("FAIL frm_drain: got %0b want 1", b_rd_empty); end
  endtask

  task automatic test_underflow();
    a_clear = 1'b1; step(); a_clear = 1'b0;
    a_rd_en = 1'b1; step(); a_rd_en = 1'b0;
    n_checks++; if (a_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %0b want 1", a_underflow); end
    n_checks++; if (a_level !== 4'd0) begin n_fail++; $display("FAIL uf_level: got %0d want 0", a_level); end
    step();
    n_checks++; if (a_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %0b want 1", a_underflow); end
    a_clear = 1'b1; step(); a_clear = 1'b0;
    n_checks++; if (a_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %0b want 0", a_underflow); end
  endtask

  task automatic test_clear_midword();
    for (int i = 0; i < 12; i++) send_a(8'(8'h50 + i));
    send_a(8'hA0); send_a(8'hA1);
    n_checks++; if (a_level !== 4'd3) begin n_fail++; $display("FAIL mid_level: got %0d want 3", a_level); end
    a_pixel = 8'hEE;
    a_clear = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %0b want 0", a_ready); end
    step();
    a_clear = 1'b0;
    n_checks++; if ({a_level, a_rd_empty} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL mid_flush: got %0d/%0b want 0/1", a_level, a_rd_empty); end
    send_a(8'hC1); send_a(8'hC2); send_a(8'hC3); send_a(8'hC4);
    a_valid = 1'b0;
    n_checks++; if (a_rd_data !== 32'hC4C3C2C1) begin n_fail++; $display("FAIL mid_fresh: got %h want c4c3c2c1", a_rd_data); end
    n_checks++; if (a_level !== 4'd1) begin n_fail++; $display("FAIL mid_fresh_level: got %0d want 1", a_level); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 5; i++) send_b(8'(i));
    b_valid = 1'b0;
    n_checks++; if (b_level !== 4'd1) begin n_fail++; $display("FAIL ar_pre_level: got %0d want 1", b_level); end
    #3 rstn = 1'b0;
    #1;
    n_checks++; if ({b_rd_empty, b_level, b_rd_data, b_rd_last} !== {1'b1, 4'd0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL ar_outputs: got %0b/%0d/%h/%0b want 1/0/0/0", b_rd_empty, b_level, b_rd_data, b_rd_last);
    end
    n_checks++; if (b_frame_sum !== 16'd0) begin n_fail++; $display("FAIL ar_sum: got %0d want 0", b_frame_sum); end
    n_checks++; if (a_level !== 4'd0) begin n_fail++; $display("FAIL ar_a_level: got %0d want 0", a_level); end
    #2 rstn = 1'b1;
    step();
    b_done_cnt = 0;
    for (int i = 1; i <= 9; i++) send_b(8'(8'h10 + i));
    b_valid = 1'b0;
    n_checks++; if (b_done_cnt !== 1) begin n_fail++; $display("FAIL ar_done: got %0d want 1", b_done_cnt); end
    n_checks++; if ({b_rd_data, b_rd_last} !== {32'h14131211, 1'b0}) begin n_fail++; $display("FAIL ar_w0: got %h/%0b want 14131211/0", b_rd_data, b_rd_last); end
    pop_b();
    n_checks++; if ({b_rd_data, b_rd_last} !== {32'h18171615, 1'b0}) begin n_fail++; $display("FAIL ar_w1: got %h/%0b want 18171615/0", b_rd_data, b_rd_last); end
    pop_b();
    n_checks++; if ({b_rd_data, b_rd_last} !== {32'h00000019, 1'b1}) begin n_fail++; $display("FAIL ar_w2: got %h/%0b want 00000019/1", b_rd_data, b_rd_last); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; b_done_cnt = 0;
    rstn = 1'b0;
    a_clear = 1'b0; a_valid = 1'b0; a_pixel = 8'h0; a_rd_en = 1'b0;
    b_clear = 1'b0; b_valid = 1'b0; b_pixel = 8'h0; b_rd_en = 1'b0;
    #23 rstn = 1'b1;
    step();
    test_reset();
    test_pack();
    test_full();
    test_frame();
    test_underflow();
    test_clear_midword();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_pack_fifo.md
Name: pixel_pack_fifo

Overview:
Downstream consumer of the pixel processing stage. It accepts 8-bit processed pixels over a valid/ready handshake and packs them four at a time into 32-bit little-endian words. Words are buffered in a small show-ahead FIFO that is read by the bus/CPU side. The block tracks frame boundaries: it tags each frame's final word and pulses a frame-done flag.

Parameters:
IMG_WIDTH, 32, pixels per line
IMG_HEIGHT, 32, lines per frame; FRAME_PIXELS = IMG_WIDTH*IMG_HEIGHT, need not be a multiple of 4
FIFO_DEPTH, 8, word entries; power of 2, at least 2

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of FIFO, packer, frame counter, status
pixel_in  input  8  pixel from the processing stage
valid_in  input  1  pixel_in valid
ready_out  output  1  block can accept a pixel this cycle
rd_data  output  32  FIFO head word; pixel 0 in [7:0], pixel 3 in [31:24]
rd_last  output  1  head word is the final word of a frame
rd_empty  output  1  FIFO empty; rd_data/rd_last are don't-care when high
rd_en  input  1  pop the head word
level  output  $clog2(FIFO_DEPTH+1)  words currently stored
frame_done  output  1  one-cycle pulse per completed frame
underflow  output  1  sticky: rd_en was seen while empty
frame_sum  output  16  per-frame checksum (see Optional Feature)

Behaviour:
- Reset is asynchronous on rstn and clears everything:
  - FIFO empty: rd_empty=1, level=0, rd_data=0, rd_last=0.
  - byte_idx=0 and pix_cnt=0.
  - frame_done=0, underflow=0, frame_sum=0.
  - A reset mid-frame discards any partial word and all FIFO contents.
- A pixel is accepted when valid_in && ready_out.
  - ready_out = !clear && !(FIFO full && accepting would complete a word).
  - A word completes on byte_idx==3, or on pix_cnt==FRAME_PIXELS-1.
  - ready_out is computed from registers and clear only. It has no combinational path from rd_en or valid_in.
- Packing:
  - An accepted pixel is written to shift-register byte byte_idx, then byte_idx increments.
  - On completion, the word is pushed with unused upper bytes zero. byte_idx returns to 0.
- Frame end:
  - pix_cnt counts accepted pixels from 0 to FRAME_PIXELS-1, then wraps to 0.
  - The word completed by pixel FRAME_PIXELS-1 is pushed with last=1.
  - frame_done pulses on the cycle after that push.
- Latency: a word appears at the FIFO head (rd_empty falls, if the FIFO was empty) on the cycle after the handshake that completed it.
- FIFO behaviour:
  - 33-bit entries (data plus last).
  - rd_data and rd_last are registered from the head entry. rd_en pops the head on the clock edge.
  - Push and pop in the same cycle leave level unchanged. This applies to a full FIFO too, but push is already blocked by ready_out when full.
  - rd_en while empty is ignored and sets underflow. underflow stays high until clear or reset.
- clear is synchronous and takes priority over push, pop and accept in the same cycle.
  - It flushes all state as reset does, except frame_sum, which holds its value.
  - Because ready_out is low during clear, no pixel is lost silently.
- Pointers wrap modulo FIFO_DEPTH. level saturates naturally at FIFO_DEPTH.

Optional Feature:
Macro PACK_CHECKSUM_EN.
- Defined: a 16-bit accumulator adds each accepted pixel, zero-extended, modulo 2^16. Its final value, including the last pixel, is latched into frame_sum in the cycle frame_done pulses. The accumulator then restarts at 0. clear zeroes the accumulator.
- Not defined: no accumulator logic is built, and frame_sum is tied to 0.

Decomposition:
- Shared package holds:
  - FRAME_PIXELS derivation
  - the packed FIFO entry type (data[31:0], last)
  - PIX_W=8 and WORD_W=32 constants
  - the byte-lane index type
- Natural sub-module: sync_fifo_sa, a generic show-ahead synchronous FIFO with WIDTH and DEPTH parameters, plus count and empty/full flags. It is instantiated with WIDTH=33.
- Packer, frame counter and checksum stay in the top level.

Test Plan:
1. Reset, then 4 pixels 0x11,0x22,0x33,0x44 back-to-back with rd_en=0 -> one cycle after the 4th handshake: rd_empty=0, rd_data=0x44332211, rd_last=0, level=1.
2. Fill with rd_en=0 until 8 words are stored, then 3 more pixels, then a 4th offered -> the 3 are accepted and ready_out=0 for the 4th. A single rd_en pop -> ready_out=1 next cycle, level stays 8 after the push.
3. IMG_WIDTH=3, IMG_HEIGHT=3, pixels 1..9 -> words 0x04030201, 0x08070605, and 0x00000009 with rd_last=1. frame_done pulses once. frame_sum=45 when PACK_CHECKSUM_EN is defined, 0 otherwise.
4. rd_en pulsed while empty -> underflow=1, level stays 0. clear -> underflow=0.
5. clear asserted after 2 pixels of a word while the FIFO holds 3 words, with valid_in high -> ready_out=0 that cycle, level=0 next cycle. The next 4 pixels form a fresh word starting at byte 0.
6. rstn dropped asynchronously mid-frame with the FIFO non-empty -> all outputs reach reset values immediately. A full frame after release packs correctly from pix_cnt 0.
